aes_input_loader: RTL and testbench
===================================

Name: aes_input_loader

Overview:
- Upstream feeder for the AES round datapath.
- Collects 32-bit words from a bus-side valid/ready stream into a 128-bit plaintext block and a 128-bit cipher key.
- Presents the block and key to the round controller/datapath (datain, keyin1 inputs) with a valid/ready handshake.
- The key persists across blocks until a new key is streamed in.

Parameters:
- WORD_W, 32, stream word width. Fixed at 32; 128/WORD_W = 4 words per block or key.
- CNT_W, 8, width of the delivered-block counter.

Ports:
- clk  input  1  system clock, rising edge
- clr_n  input  1  asynchronous active-low reset
- s_valid  input  1  stream word valid
- s_ready  output  1  loader can accept a word this cycle
- s_data  input  32  stream word
- s_is_key  input  1  1 = s_data is a key word, 0 = plaintext word
- abort  input  1  synchronous flush of partial data/key assembly
- blk_valid  output  1  datain/keyin hold a complete block plus valid key
- blk_ready  input  1  controller takes the block (pulses with its load_in)
- datain  output  128  assembled plaintext block
- keyin  output  128  assembled key
- key_valid  output  1  a complete key is held
- blk_cnt  output  CNT_W  blocks delivered, wraps modulo 2^CNT_W

Behaviour:
- Reset (clr_n low, asynchronous):
  - state = FILL; data_cnt = key_cnt = 0.
  - datain = keyin = 0; key_valid = 0; blk_valid = 0; blk_cnt = 0.
  - s_ready = 0 while clr_n is low.
- Word transfer occurs on a rising edge with s_valid & s_ready.
- Word order: the first word lands in bits [127:96], then [95:64], [63:32], [31:0].
  - Implemented as a left shift-in: reg <= {reg[95:0], s_data}.
- Key words:
  - Accepting a key word with key_cnt = 0 clears key_valid in the same edge (a new key is in progress).
  - key_cnt increments on each key word.
  - On the 4th key word: key_cnt -> 0 and key_valid -> 1.
- Data words: data_cnt increments; the 4th word completes the block (data_cnt -> 0, data_full internal flag = 1).
- States:
  - FILL:
    - s_ready = 1 (when clr_n is high).
    - On the edge that completes data: go to HOLD if key_valid is (or becomes on that edge) 1, else go to WAIT_KEY.
  - WAIT_KEY:
    - s_ready = s_is_key (data words stall, key words accepted).
    - Go to HOLD on the edge where key_valid becomes 1.
  - HOLD:
    - s_ready = 0; blk_valid = 1.
    - datain and keyin are stable until transfer.
    - On blk_valid & blk_ready: go to FILL, blk_cnt += 1, data_full = 0.
- Latency:
  - blk_valid rises the cycle after the edge accepting the final needed word (data or key).
  - There is no combinational path from s_valid to blk_valid.
- After a HOLD transfer, s_ready = 1 in the next cycle. A word presented in the same cycle as the transfer is not accepted.
- blk_ready outside HOLD is ignored.
- abort (synchronous, highest priority after reset):
  - data_cnt = 0, key_cnt = 0, data_full = 0, blk_valid = 0, state = FILL.
  - key_valid is kept only if no key load was partial (key_cnt was 0). A partial key clears key_valid.
  - datain and keyin contents are not cleared.
  - A word offered in an abort cycle is dropped.
- blk_cnt wraps from 2^CNT_W - 1 to 0.
- Reset asserted mid-block discards all partial state; the next block starts from word 0.

Test Plan:
- Reset, then 4 key words 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c, then 4 data words 0x3243f6a8, 0x885a308d, 0x313198a2, 0xe0370734 -> key_valid = 1, then the cycle after the 4th data word blk_valid = 1:
  - datain = 0x3243f6a8885a308d313198a2e0370734
  - keyin = 0x2b7e151628aed2a6abf7158809cf4f3c
- In HOLD, hold blk_ready = 0 for 5 cycles while s_valid = 1 -> s_ready = 0, outputs stable. Then blk_ready = 1 for one cycle -> blk_cnt = 1, and s_ready = 1 the next cycle.
- Send 4 data words with no key loaded -> WAIT_KEY; a data word with s_is_key = 0 sees s_ready = 0. Then 4 key words -> blk_valid the cycle after the 4th key word.
- After a valid key, send 2 key words, then abort -> key_valid = 0, counters 0. A following full key + block is delivered correctly.
- Deliver 256 blocks with one key and blk_ready tied high -> key reused, blk_cnt wraps to 0.
- Assert clr_n low after 2 data words, release, send 4 fresh data words plus a key -> datain contains only the fresh words.

Source files
------------

// File: rtl/aes_input_loader.sv
// AES input loader: packs 32-bit stream words into a plaintext block and key.
// Hands the block plus current key to the round datapath over valid/ready.
module aes_input_loader #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_is_key,
   input  logic              abort,
   output logic              blk_valid,
   input  logic              blk_ready,
   output logic [127:0]      datain,
   output logic [127:0]      keyin,
   output logic              key_valid,
   output logic [CNT_W-1:0]  blk_cnt
);

   localparam logic [1:0] LAST = 2'd3;

   typedef enum logic [1:0] {
      FILL     = 2'd0,
      WAIT_KEY = 2'd1,
      HOLD     = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] data_cnt;
   logic [1:0] key_cnt;
   logic       key_valid_nxt;
   logic       take;
   logic       key_take;
   logic       data_take;
   logic       key_last;
   logic       data_last;
   logic       blk_xfer;

   // Stream-side ready: data words stall while a block waits for its key.
   always_comb begin
      s_ready = 1'b0;
      unique case (state)
         FILL:     s_ready = 1'b1;
         WAIT_KEY: s_ready = s_is_key;
         HOLD:     s_ready = 1'b0;
         default:  s_ready = 1'b0;
      endcase
      if (!clr_n) s_ready = 1'b0;
   end

   // Word acceptance qualifiers; an abort cycle drops the offered word.
   always_comb begin
      take      = s_valid & s_ready & ~abort;
      key_take  = take & s_is_key;
      data_take = take & ~s_is_key;
      key_last  = key_take & (key_cnt == LAST);
      data_last = data_take & (data_cnt == LAST);
      blk_xfer  = (state == HOLD) & blk_ready & ~abort;
   end

   // Key-valid tracking: a fresh key load invalidates the old key.
   always_comb begin
      key_valid_nxt = key_valid;
      if (abort) begin
         if (key_cnt != 2'd0) key_valid_nxt = 1'b0;
      end else if (key_take) begin
         if (key_cnt == 2'd0) key_valid_nxt = 1'b0;
         if (key_last)        key_valid_nxt = 1'b1;
      end
   end

   // Next-state logic for the fill / wait-for-key / hold sequencing.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = FILL;
      end else begin
         unique case (state)
            FILL: begin
               if (data_last)
                  state_nxt = key_valid_nxt ? HOLD : WAIT_KEY;
            end
            WAIT_KEY: begin
               if (key_last) state_nxt = HOLD;
            end
            HOLD: begin
               if (blk_ready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state <= FILL;
      else        state <= state_nxt;
   end

   // Word counters for the partial block and partial key.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         data_cnt <= 2'd0;
         key_cnt  <= 2'd0;
      end else if (abort) begin
         data_cnt <= 2'd0;
         key_cnt  <= 2'd0;
      end else begin
         if (data_take) data_cnt <= data_cnt + 2'd1;
         if (key_take)  key_cnt  <= key_cnt + 2'd1;
      end
   end

   // Shift-in assembly: first word ends up in the top 32 bits.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         datain <= '0;
         keyin  <= '0;
      end else begin
         if (data_take) datain <= {datain[127-WORD_W:0], s_data};
         if (key_take)  keyin  <= {keyin[127-WORD_W:0], s_data};
      end
   end

   // Key-valid register.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) key_valid <= 1'b0;
      else        key_valid <= key_valid_nxt;
   end

   // Delivered-block counter, wraps naturally.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)        blk_cnt <= '0;
      else if (blk_xfer) blk_cnt <= blk_cnt + CNT_W'(1);
   end

   // Block valid comes straight from the registered state.
   always_comb begin
      blk_valid = (state == HOLD);
   end

endmodule

// File: tb/tb_aes_input_loader.sv
// Bench for aes_input_loader: directed scenarios plus random traffic,
// all checked against a word-queue reference model.
module tb_aes_input_loader;

   logic         clk = 1'b0;
   logic         clr_n;
   logic         s_valid;
   logic         s_ready;
   logic [31:0]  s_data;
   logic         s_is_key;
   logic         abort;
   logic         blk_valid;
   logic         blk_ready;
   logic [127:0] datain;
   logic [127:0] keyin;
   logic         key_valid;
   logic [7:0]   blk_cnt;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] dh[$];
   logic [31:0] kh[$];
   int          dq_n;
   int          kq_n;
   bit          kv;
   int          mcnt;

   aes_input_loader #(.WORD_W(32), .CNT_W(8)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_is_key  (s_is_key),
      .abort     (abort),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .datain    (datain),
      .keyin     (keyin),
      .key_valid (key_valid),
      .blk_cnt   (blk_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] last4(input logic [31:0] q[$]);
      logic [127:0] r = '0;
      for (int i = 0; i < q.size(); i++) r = {r[95:0], q[i]};
      return r;
   endfunction

   function automatic bit m_hold();
      return (dq_n == 4) && kv;
   endfunction

   function automatic bit m_ready(input bit k);
      if (m_hold()) return 1'b0;
      return (dq_n < 4) || k;
   endfunction

   task automatic model_clear();
      dh.delete();
      kh.delete();
      dq_n = 0;
      kq_n = 0;
      kv   = 0;
      mcnt = 0;
   endtask

   task automatic chk_outs(input string pfx);
      chk({pfx, "_blk_valid"}, blk_valid, m_hold());
      chk({pfx, "_key_valid"}, key_valid, kv);
      chk({pfx, "_datain"}, datain, last4(dh));
      chk({pfx, "_keyin"}, keyin, last4(kh));
      chk({pfx, "_blk_cnt"}, blk_cnt, mcnt[7:0]);
   endtask

   // one clock cycle: drive, check ready, advance model, check outputs
   task automatic cyc(input bit v, input logic [31:0] d, input bit k,
                      input bit ab, input bit br);
      bit er;
      s_valid   = v;
      s_data    = d;
      s_is_key  = k;
      abort     = ab;
      blk_ready = br;
      #1;
      er = m_ready(k);
      chk("s_ready", s_ready, er);
      if (ab) begin
         if (kq_n != 0) kv = 0;
         kq_n = 0;
         dq_n = 0;
      end else if (m_hold()) begin
         if (br) begin
            dq_n = 0;
            mcnt = (mcnt + 1) % 256;
         end
      end else if (v && er) begin
         if (k) begin
            if (kq_n == 0) kv = 0;
            kh.push_back(d);
            if (kh.size() > 4) void'(kh.pop_front());
            kq_n++;
            if (kq_n == 4) begin
               kq_n = 0;
               kv = 1;
            end
         end else begin
            dh.push_back(d);
            if (dh.size() > 4) void'(dh.pop_front());
            dq_n++;
         end
      end
      @(posedge clk);
      #1;
      chk_outs("cyc");
      @(negedge clk);
   endtask

   task automatic do_reset();
      clr_n     = 1'b0;
      s_valid   = 1'b1;
      s_data    = 32'hdead_beef;
      s_is_key  = 1'b0;
      abort     = 1'b0;
      blk_ready = 1'b0;
      #2;
      model_clear();
      chk("rst_s_ready", s_ready, 0);
      chk_outs("rst");
      @(negedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      clr_n   = 1'b1;
   endtask

   logic [31:0] key_v[4] = '{32'h2b7e1516, 32'h28aed2a6,
                             32'habf71588, 32'h09cf4f3c};
   logic [31:0] dat_v[4] = '{32'h3243f6a8, 32'h885a308d,
                             32'h313198a2, 32'he0370734};

   initial begin
      do_reset();
      chk("rst_datain0", datain, 128'h0);
      chk("rst_cnt0", blk_cnt, 0);

      // FIPS-197 vector
      for (int i = 0; i < 4; i++) cyc(1, key_v[i], 1, 0, 0);
      chk("fips_key_valid", key_valid, 1);
      for (int i = 0; i < 4; i++) cyc(1, dat_v[i], 0, 0, 0);
      chk("fips_blk_valid", blk_valid, 1);
      chk("fips_datain", datain,
          128'h3243f6a8885a308d313198a2e0370734);
      chk("fips_keyin", keyin,
          128'h2b7e151628aed2a6abf7158809cf4f3c);

      // stall in HOLD, then transfer with a word offered
      for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0, 0);
      cyc(1, 32'h1111_2222, 0, 0, 1);
      chk("xfer_cnt", blk_cnt, 1);
      chk("xfer_blk_valid", blk_valid, 0);
      chk("post_xfer_ready", s_ready, 1);

      // block without key -> WAIT_KEY
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0, 0);
      chk("waitkey_blk_valid", blk_valid, 0);
      cyc(1, 32'h5555_aaaa, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, $urandom, 1, 0, 0);
      chk("waitkey_partial", blk_valid, 0);
      cyc(1, 32'h0f0f_f0f0, 1, 0, 0);
      chk("waitkey_done", blk_valid, 1);
      cyc(0, 0, 0, 0, 1);

      // partial key then abort
      cyc(1, 32'h0000_0001, 1, 0, 0);
      cyc(1, 32'h0000_0002, 1, 0, 0);
      chk("partial_kv", key_valid, 0);
      cyc(1, 32'h0000_0003, 1, 1, 0);
      chk("abort_kv", key_valid, 0);
      for (int i = 0; i < 4; i++) cyc(1, key_v[i], 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, dat_v[i], 0, 0, 0);
      chk("abort_keyin", keyin,
          128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("abort_blk", blk_valid, 1);
      cyc(0, 0, 0, 0, 1);

      // 256 blocks with one key, counter wraps
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, key_v[i], 1, 0, 0);
      for (int b = 0; b < 256; b++)
         for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0, 1);
      chk("wrap_cnt", blk_cnt, 0);
      chk("wrap_kv", key_valid, 1);

      // reset mid-block
      cyc(1, 32'hbad0_0001, 0, 0, 0);
      cyc(1, 32'hbad0_0002, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, dat_v[i], 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, key_v[i], 1, 0, 0);
      chk("midrst_datain", datain,
          128'h3243f6a8885a308d313198a2e0370734);
      chk("midrst_blk", blk_valid, 1);

      // random traffic
      for (int n = 0; n < 3000; n++)
         cyc($urandom_range(0, 3) != 0, $urandom,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 1) == 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
